alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL expose clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL expose rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose start  input  1  operation request; sampled on rising clk.
REQ-004 SHALL expose alu_control  input  4  operation code from ALUControl: 0000 ADD, 0001 SUB, 0010 MULT, 0011 DIV, 0100 MOV, 0101 MOVI; other codes invalid.
REQ-005 SHALL expose a  input  32  operand A (rs).
REQ-006 SHALL expose b  input  32  operand B (rt or immediate).
REQ-007 SHALL expose result  output  32  operation result, held until the next accepted start.
REQ-008 SHALL expose remainder  output  32  DIV remainder; 0 for all other operations.
REQ-009 SHALL expose busy  output  1  high while the operation executes.
REQ-010 SHALL expose done  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL expose zero  output  1  high when result == 0, updated with done.
REQ-012 SHALL expose ovf  output  1  signed overflow for ADD/SUB, 0 otherwise.
REQ-013 SHALL expose err  output  1  high for invalid opcode or DIV by zero, updated with done.

Function
REQ-014 SHALL implement states IDLE, EXEC, DONE.
REQ-015 SHALL accept start only in IDLE or DONE; capture alu_control, a, b on that edge and enter EXEC.
REQ-016 SHALL ignore start while in EXEC; captured operands are unaffected.
REQ-017 SHALL hold busy=1 in EXEC only; done=1 in DONE only; DONE lasts one cycle, then IDLE unless start is accepted.
REQ-018 SHALL spend 1 EXEC cycle for ADD, SUB, MOV, MOVI, invalid codes and DIV by zero: done high 2 cycles after the start edge.
REQ-019 SHALL spend 32 EXEC cycles for MULT and DIV: done high 33 cycles after the start edge.
REQ-020 SHALL compute ADD/SUB modulo 2^32; ovf = operand signs equal (ADD) or different (SUB) and result sign differs from A.
REQ-021 SHALL compute MULT as unsigned shift-add, one bit per cycle; result = low 32 bits of a*b.
REQ-022 SHALL compute DIV as unsigned restoring division, one bit per cycle; result = a/b, remainder = a%b.
REQ-023 SHALL treat DIV with b==0 as error: result=32'hFFFFFFFF, remainder=a, err=1.
REQ-024 SHALL implement MOV as result=a and MOVI as result=b.
REQ-025 SHALL produce result=0, err=1, zero=1 for invalid opcodes.
REQ-026 SHALL keep result, remainder, zero, ovf, err stable from DONE until the next DONE.

Reset
REQ-027 SHALL on rst=1, regardless of clk, force state IDLE and all outputs to 0, aborting any EXEC in progress.
REQ-028 SHALL require a fresh start after rst deasserts; no partial result is ever signalled.

Configuration
REQ-029 SHALL compile the MULT/DIV iterative datapath only when ALU_MULDIV_EN is defined.
REQ-030 SHALL, without ALU_MULDIV_EN, treat codes 0010 and 0011 as invalid per REQ-025, with 2-cycle latency and no multiplier/divider logic synthesized.

Verification
REQ-031 SHALL verify ADD a=32'h7FFFFFFF, b=1 -> result=32'h80000000, ovf=1, zero=0, done 2 cycles after start.
REQ-032 SHALL verify SUB a=5, b=5 -> result=0, zero=1, ovf=0; then MOVI b=32'h1234 -> result=32'h1234.
REQ-033 SHALL verify MULT a=1000, b=3000 -> result=3000000, busy high 32 cycles, done 33 cycles after start (ALU_MULDIV_EN defined).
REQ-034 SHALL verify DIV a=100, b=7 -> result=14, remainder=2; DIV a=9, b=0 -> result=32'hFFFFFFFF, remainder=9, err=1 after 2 cycles.
REQ-035 SHALL verify reset mid-operation: assert rst at EXEC cycle 10 of MULT -> busy=0, done never pulses, and the next ADD 2+3 -> result=5.
REQ-036 SHALL verify start pulsed during EXEC of DIV is ignored, and opcode 1111 -> result=0, err=1.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU sequenced by an IDLE/EXEC/DONE controller.
// Define ALU_MULDIV_EN to build the iterative shift-add MULT / restoring DIV datapath.
module alu_multicycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  alu_control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic        ovf,
  output logic        err
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_MOVI = 4'b0101;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] result_q, result_d, rem_q, rem_d;
  logic        zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        fin_s;
  logic [31:0] res_s, rem_s, add_s, sub_s;
  logic        ovf_s, err_s;

`ifdef ALU_MULDIV_EN
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] mul_sum_s, div_sh_s, div_diff_s;
`endif

  assign add_s = a_q + b_q;
  assign sub_s = a_q - b_q;

`ifdef ALU_MULDIV_EN
  // MULT keeps {hi,lo} as a right-shifting product; DIV shifts the dividend out of lo into hi.
  assign mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : 33'd0);
  assign div_sh_s   = {hi_q, lo_q[31]};
  assign div_diff_s = div_sh_s - {1'b0, b_q};
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    rem_d    = rem_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    fin_s    = 1'b0;
    res_s    = 32'd0;
    rem_s    = 32'd0;
    ovf_s    = 1'b0;
    err_s    = 1'b0;
`ifdef ALU_MULDIV_EN
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_EXEC;
          op_d    = alu_control;
          a_d     = a;
          b_d     = b;
`ifdef ALU_MULDIV_EN
          hi_d    = 32'd0;
          lo_d    = (alu_control == OP_MULT) ? b : a;
          cnt_d   = 5'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        fin_s   = 1'b1;
        case (op_q)
          OP_ADD: begin
            res_s = add_s;
            ovf_s = (a_q[31] == b_q[31]) && (add_s[31] != a_q[31]);
          end
          OP_SUB: begin
            res_s = sub_s;
            ovf_s = (a_q[31] != b_q[31]) && (sub_s[31] != a_q[31]);
          end
          OP_MOV:  res_s = a_q;
          OP_MOVI: res_s = b_q;
`ifdef ALU_MULDIV_EN
          OP_MULT: begin
            hi_d  = mul_sum_s[32:1];
            lo_d  = {mul_sum_s[0], lo_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            res_s = lo_d;
            if (cnt_q != 5'd31) begin
              state_d = S_EXEC;
              fin_s   = 1'b0;
            end else begin
              state_d = S_DONE;
            end
          end
          OP_DIV: begin
            if (b_q == 32'd0) begin
              res_s = 32'hFFFF_FFFF;
              rem_s = a_q;
              err_s = 1'b1;
            end else begin
              if (!div_diff_s[32]) begin
                hi_d = div_diff_s[31:0];
                lo_d = {lo_q[30:0], 1'b1};
              end else begin
                hi_d = div_sh_s[31:0];
                lo_d = {lo_q[30:0], 1'b0};
              end
              cnt_d = cnt_q + 5'd1;
              res_s = lo_d;
              rem_s = hi_d;
              if (cnt_q != 5'd31) begin
                state_d = S_EXEC;
                fin_s   = 1'b0;
              end else begin
                state_d = S_DONE;
              end
            end
          end
`endif
          default: err_s = 1'b1;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // Result flags only move on the final EXEC cycle so they stay stable between DONEs.
    if (fin_s) begin
      result_d = res_s;
      rem_d    = rem_s;
      zero_d   = (res_s == 32'd0);
      ovf_d    = ovf_s;
      err_d    = err_s;
    end else begin
      result_d = result_q;
    end
    busy_d = (state_d == S_EXEC);
    done_d = (state_d == S_DONE);
  end

  // State, captured operands and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 4'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
      rem_q    <= 32'd0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      cnt_q    <= 5'd0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_MULDIV_EN
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign result    = result_q;
  assign remainder = rem_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle; expectations track ALU_MULDIV_EN.
module tb_alu_multicycle;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_MOVI = 4'b0101;
`ifdef ALU_MULDIV_EN
  localparam bit         MD      = 1'b1;
  localparam int         RST_CUT = 10;
  localparam logic [3:0] RST_OP  = OP_MULT;
`else
  localparam bit         MD      = 1'b0;
  localparam int         RST_CUT = 1;
  localparam logic [3:0] RST_OP  = OP_ADD;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  alu_control;
  logic [31:0] a, b, result, remainder;
  logic        busy, done, zero, ovf, err;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        z;
    logic        o;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_multicycle dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .result(result), .remainder(remainder),
    .busy(busy), .done(done), .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t m;
    logic [63:0] p;
    m.res = 32'd0; m.rem = 32'd0; m.o = 1'b0; m.e = 1'b0;
    case (op)
      OP_ADD: begin
        m.res = x + y;
        m.o   = (x[31] == y[31]) && (m.res[31] != x[31]);
      end
      OP_SUB: begin
        m.res = x - y;
        m.o   = (x[31] != y[31]) && (m.res[31] != x[31]);
      end
      OP_MOV:  m.res = x;
      OP_MOVI: m.res = y;
      OP_MULT: begin
        if (MD) begin
          p     = {32'd0, x} * {32'd0, y};
          m.res = p[31:0];
        end else m.e = 1'b1;
      end
      OP_DIV: begin
        if (!MD) m.e = 1'b1;
        else if (y == 32'd0) begin
          m.res = 32'hFFFF_FFFF; m.rem = x; m.e = 1'b1;
        end else begin
          m.res = x / y; m.rem = x % y;
        end
      end
      default: m.e = 1'b1;
    endcase
    m.z = (m.res == 32'd0);
    return m;
  endfunction

  // Output monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) check_eq("spurious_done", 32'(done), 32'd0);
      else begin
        mon_e = sb_q.pop_front();
        check_eq("result",    result,    mon_e.res);
        check_eq("remainder", remainder, mon_e.rem);
        check_eq("zero",      32'(zero), 32'(mon_e.z));
        check_eq("ovf",       32'(ovf),  32'(mon_e.o));
        check_eq("err",       32'(err),  32'(mon_e.e));
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input bit poke);
    int   lat, bcnt, exp_lat;
    exp_t m;
    m = model(op, x, y);
    sb_q.push_back(m);
    exp_lat = (MD && (op == OP_MULT || (op == OP_DIV && y != 32'd0))) ? 33 : 2;
    @(negedge clk);
    start = 1'b1; alu_control = op; a = x; b = y;
    @(posedge clk);
    lat = 1; bcnt = 0;
    @(negedge clk);
    if (poke) begin
      alu_control = OP_ADD; a = ~x; b = 32'h55;
    end else start = 1'b0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    check_eq("latency",     32'(lat),  32'(exp_lat));
    check_eq("busy_cycles", 32'(bcnt), 32'(exp_lat - 1));
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_not_busy",  32'(busy), 32'd0);
    check_eq("result_held",    result,    m.res);
  endtask

  task automatic reset_mid(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input int cut);
    int dn, bs;
    dn = 0; bs = 0;
    @(negedge clk);
    start = 1'b1; alu_control = op; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (cut - 1) @(negedge clk);
    check_eq("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_busy",   32'(busy), 32'd0);
    check_eq("rst_done",   32'(done), 32'd0);
    check_eq("rst_result", result,    32'd0);
    check_eq("rst_rem",    remainder, 32'd0);
    check_eq("rst_err",    32'(err),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bs++;
    end
    check_eq("no_done_after_rst", 32'(dn), 32'd0);
    check_eq("no_busy_after_rst", 32'(bs), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_control = 4'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("init_busy",   32'(busy), 32'd0);
    check_eq("init_done",   32'(done), 32'd0);
    check_eq("init_result", result,    32'd0);
    check_eq("init_zero",   32'(zero), 32'd0);
    check_eq("init_err",    32'(err),  32'd0);
    rst = 1'b0;

    run_op(OP_ADD,  32'h7FFF_FFFF, 32'd1,         1'b0);
    run_op(OP_SUB,  32'd5,         32'd5,         1'b0);
    run_op(OP_MOVI, 32'hAAAA_0000, 32'h1234,      1'b0);
    run_op(OP_ADD,  32'hFFFF_FFFF, 32'd1,         1'b0);
    run_op(OP_SUB,  32'h8000_0000, 32'd1,         1'b0);
    run_op(OP_SUB,  32'd3,         32'd10,        1'b0);
    run_op(OP_MULT, 32'd1000,      32'd3000,      1'b0);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIV,  32'd100,       32'd7,         1'b0);
    run_op(OP_DIV,  32'd9,         32'd0,         1'b0);
    run_op(OP_DIV,  32'hFFFF_FFFF, 32'd16,        1'b1);
    run_op(OP_DIV,  32'd3,         32'd5,         1'b0);
    run_op(4'b1111, 32'd77,        32'd88,        1'b0);
    run_op(4'b0110, 32'd1,         32'd2,         1'b0);
    run_op(OP_MOV,  32'hDEAD_BEEF, 32'd0,         1'b0);

    reset_mid(RST_OP, 32'd1000, 32'd3000, RST_CUT);
    run_op(OP_ADD, 32'd2, 32'd3, 1'b0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
